dmem_hs: RTL and testbench

- Parametrised successor to the single-cycle data memory.
- Word-organised data RAM with byte-lane write enables and a valid/ready request port.
- Programmable fixed access latency so the pipelined core can be tested against slow memory (stall on !req_ready / !rsp_valid).
- Sits between the core's memory stage and the memory array; flags misaligned and out-of-range accesses instead of aliasing them.

---
 rtl/dmem_hs.sv | 118 +++++++++++
 tb/tb_dmem_hs.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_hs.sv
// Word-organised data RAM with byte-lane write enables, a valid/ready request port
// and a programmable fixed response latency; misaligned/out-of-range accesses are flagged.
module dmem_hs #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);
  localparam int unsigned BYTES = DEPTH * BE_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               accept;
  logic               req_err;
  logic [IDX_W-1:0]   idx;
  logic [DATA_W-1:0]  rd_now;
  logic [DATA_W-1:0]  hold_rdata;
  logic               hold_err;
  logic [DATA_W-1:0]  mem [DEPTH];

  assign req_ready = (state == IDLE) || (state == RESP);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;

  // Error instead of aliasing: low offset bits set, or beyond the array.
  assign req_err = ((req_addr & ADDR_W'(BE_W - 1)) != '0) || (req_addr >= ADDR_W'(BYTES));
  assign idx     = IDX_W'(req_addr >> OFF_W);
  assign rd_now  = (req_we || req_err) ? '0 : mem[idx];

  // Next-state and latency counter.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          if (LATENCY >= 2) begin
            state_next = WAIT;
            cnt_next   = CNT_W'(LATENCY - 1);
          end else begin
            state_next = RESP;
          end
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_next = RESP;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Holding register and registered response; data is zero outside the response cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_rdata <= '0;
      hold_err   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        hold_rdata <= rd_now;
        hold_err   <= req_err;
      end
      rsp_valid <= (state_next == RESP);
      if (state_next == RESP) begin
        rsp_rdata <= accept ? rd_now : hold_rdata;
        rsp_err   <= accept ? req_err : hold_err;
      end else begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

  // Array is not reset; writes commit at the acceptance edge.
  always_ff @(posedge clk) begin
    if (accept && reset && req_we && !req_err) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_hs.sv
// Self-checking bench for dmem_hs: a LATENCY=3 instance and a LATENCY=1 instance
// checked against an array-based reference memory with randomized traffic.
module tb_dmem_hs;

  localparam int unsigned LAT_A = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        a_valid = 1'b0, a_ready, a_we = 1'b0, a_rsp_valid, a_rsp_err, a_busy;
  logic [3:0]  a_be = '0;
  logic [31:0] a_addr = '0, a_wdata = '0, a_rsp_rdata;

  logic        b_valid = 1'b0, b_ready, b_we = 1'b0, b_rsp_valid, b_rsp_err, b_busy;
  logic [3:0]  b_be = '0;
  logic [31:0] b_addr = '0, b_wdata = '0, b_rsp_rdata;

  logic [31:0] ref_a [64];
  logic [31:0] ref_b [64];

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  dmem_hs #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .LATENCY(LAT_A)) u_dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we), .req_be(a_be),
    .req_addr(a_addr), .req_wdata(a_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err), .busy(a_busy)
  );

  dmem_hs #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .LATENCY(1)) u_dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we), .req_be(b_be),
    .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request on instance sel (0: LATENCY=3, 1: LATENCY=1); caller sits at a negedge.
  task automatic txn(input bit sel, input bit we, input logic [3:0] be,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input string tag, output logic [31:0] got, output int waited);
    bit          e_err;
    logic [31:0] e_rd;
    int          w, lat;
    if (!sel) begin a_valid = 1; a_we = we; a_be = be; a_addr = addr; a_wdata = wd; end
    else      begin b_valid = 1; b_we = we; b_be = be; b_addr = addr; b_wdata = wd; end
    waited = 0;
    got    = '0;
    while (!(sel ? b_ready : a_ready)) begin
      @(negedge clk);
      waited++;
      if (waited > 20) begin
        chk({tag, "_ready_timeout"}, 32'(sel ? b_ready : a_ready), 32'd1);
        a_valid = 0; b_valid = 0;
        return;
      end
    end
    @(posedge clk);
    #1;
    if (!sel) a_valid = 0; else b_valid = 0;

    // Reference: plain byte-addressed rules, serialised requests.
    e_err = (addr % 4 != 0) || (addr >= 256);
    w     = int'(addr / 4) % 64;
    e_rd  = (we || e_err) ? 32'h0 : (sel ? ref_b[w] : ref_a[w]);
    if (we && !e_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          if (sel) ref_b[w][8*i +: 8] = wd[8*i +: 8];
          else     ref_a[w][8*i +: 8] = wd[8*i +: 8];
        end
      end
    end

    lat = sel ? 1 : int'(LAT_A);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k < lat) begin
        chk({tag, "_early_valid"}, 32'(a_rsp_valid), 32'd0);
        chk({tag, "_early_rdata"}, a_rsp_rdata, 32'd0);
        chk({tag, "_wait_ready"}, 32'(a_ready), 32'd0);
      end else begin
        chk({tag, "_valid"}, 32'(sel ? b_rsp_valid : a_rsp_valid), 32'd1);
        chk({tag, "_rdata"}, sel ? b_rsp_rdata : a_rsp_rdata, e_rd);
        chk({tag, "_err"},   32'(sel ? b_rsp_err : a_rsp_err), 32'(e_err));
        got = sel ? b_rsp_rdata : a_rsp_rdata;
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0)      return 32'($urandom_range(0, 255)) | 32'd1;
    else if (r == 1) return 32'd256 + 32'($urandom_range(0, 63)) * 32'd4;
    else             return 32'($urandom_range(0, 63)) * 32'd4;
  endfunction

  initial begin
    logic [31:0] got, rw;
    int          wt;

    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);

    // Fill both memories so every reference word is known.
    for (int w = 0; w < 64; w++) txn(0, 1, 4'hF, 32'(w) * 32'd4, $urandom, "init_a", got, wt);
    for (int w = 0; w < 64; w++) txn(1, 1, 4'hF, 32'(w) * 32'd4, $urandom, "init_b", got, wt);

    // Reset held with a write pending: no response, no commit.
    @(negedge clk);
    reset = 0;
    a_valid = 1; a_we = 1; a_be = 4'hF; a_addr = 32'h0; a_wdata = 32'hFFFF_FFFF;
    b_valid = 1; b_we = 1; b_be = 4'hF; b_addr = 32'h0; b_wdata = 32'hFFFF_FFFF;
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid", 32'(a_rsp_valid), 32'd0);
      chk("rst_rdata", a_rsp_rdata, 32'd0);
      chk("rst_busy",  32'(a_busy), 32'd0);
      chk("rst_valid_b", 32'(b_rsp_valid), 32'd0);
    end
    a_valid = 0; b_valid = 0;
    reset = 1;
    #1;
    chk("rel_ready_a", 32'(a_ready), 32'd1);
    chk("rel_ready_b", 32'(b_ready), 32'd1);
    @(negedge clk);
    txn(0, 0, 4'h0, 32'h0, 32'h0, "rst_nowrite_a", got, wt);
    txn(1, 0, 4'h0, 32'h0, 32'h0, "rst_nowrite_b", got, wt);

    // Latency and basic write/read.
    txn(0, 1, 4'hF, 32'h10, 32'hDEAD_BEEF, "lat_wr", got, wt);
    txn(0, 0, 4'h0, 32'h10, 32'h0, "lat_rd", got, wt);
    chk("lat_rd_const", got, 32'hDEAD_BEEF);

    // Byte-lane merge.
    txn(0, 1, 4'hF, 32'h20, 32'h1122_3344, "be_init", got, wt);
    txn(0, 1, 4'h5, 32'h20, 32'hAABB_CCDD, "be_wr", got, wt);
    txn(0, 0, 4'h0, 32'h20, 32'h0, "be_rd", got, wt);
    chk("be_merge", got, 32'h11BB_33DD);
    txn(0, 1, 4'h0, 32'h20, 32'hFFFF_FFFF, "be_zero_wr", got, wt);
    txn(0, 0, 4'h0, 32'h20, 32'h0, "be_zero_rd", got, wt);
    chk("be_zero_const", got, 32'h11BB_33DD);

    // Back-to-back: each request accepted in the response cycle of the previous.
    txn(0, 0, 4'h0, 32'h0, 32'h0, "b2b0", got, wt);
    txn(0, 0, 4'h0, 32'h4, 32'h0, "b2b1", got, wt);
    chk("b2b1_nowait", 32'(wt), 32'd0);
    txn(0, 0, 4'h0, 32'h8, 32'h0, "b2b2", got, wt);
    chk("b2b2_nowait", 32'(wt), 32'd0);

    // Errors.
    txn(0, 0, 4'h0, 32'h12, 32'h0, "err_mis", got, wt);
    txn(0, 1, 4'hF, 32'h100, 32'h5555_AAAA, "err_oor", got, wt);
    txn(0, 0, 4'h0, 32'h0, 32'h0, "err_word0", got, wt);

    // Reset in cycle 2 of an accepted write: no response, write stays committed.
    rw = $urandom;
    a_valid = 1; a_we = 1; a_be = 4'hF; a_addr = 32'h8; a_wdata = rw;
    @(posedge clk);
    #1 a_valid = 0;
    ref_a[2] = rw;
    @(posedge clk);
    #1 reset = 0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_valid", 32'(a_rsp_valid), 32'd0);
      chk("midrst_busy",  32'(a_busy), 32'd0);
    end
    reset = 1;
    repeat (5) begin
      @(negedge clk);
      chk("post_valid", 32'(a_rsp_valid), 32'd0);
      chk("post_busy",  32'(a_busy), 32'd0);
      chk("post_ready", 32'(a_ready), 32'd1);
    end
    txn(0, 0, 4'h0, 32'h8, 32'h0, "midrst_rd", got, wt);
    chk("midrst_data", got, rw);

    // LATENCY=1 back-to-back reads.
    txn(1, 0, 4'h0, 32'h0, 32'h0, "l1_b2b0", got, wt);
    txn(1, 0, 4'h0, 32'h4, 32'h0, "l1_b2b1", got, wt);
    chk("l1_b2b1_nowait", 32'(wt), 32'd0);
    txn(1, 0, 4'h0, 32'h8, 32'h0, "l1_b2b2", got, wt);
    chk("l1_b2b2_nowait", 32'(wt), 32'd0);

    // Randomized traffic on both instances.
    for (int n = 0; n < 80; n++) begin
      txn(0, 1'($urandom_range(0, 1)), 4'($urandom), rand_addr(), $urandom, "rnd_a", got, wt);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int n = 0; n < 80; n++) begin
      txn(1, 1'($urandom_range(0, 1)), 4'($urandom), rand_addr(), $urandom, "rnd_b", got, wt);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    @(negedge clk);
    chk("end_valid_b", 32'(b_rsp_valid), 32'd0);
    chk("end_rdata_b", b_rsp_rdata, 32'd0);
    chk("end_busy_a",  32'(a_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
